// File: rtl/hazard_forwarding_unit_pkg.sv
`default_nettype none
// ============================================================================
// Package   : pipeline_pkg
// Purpose   : Shared forwarding-select encodings, the PC register index and
//             the destination-info record carried by the hazard unit's
//             shadow pipeline.
// Revision  : 1.0 - initial release
// ============================================================================
package pipeline_pkg;

  // Default widths; the hazard unit parameters default to these values.
  localparam int DEF_RADDR_W = 4;
  localparam int DEF_CNT_W   = 8;

  // Register index that always reads from the RF/PC path.
  localparam int PC_REG = 15;

  // Operand mux select encodings shared by PA, PB and PD.
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  // Destination information tracked for an instruction in flight.
  typedef struct packed {
    logic [DEF_RADDR_W-1:0] dest;
    logic                   rf_e;
    logic                   load;
  } dest_info_t;

  localparam dest_info_t DEST_NONE = '{dest: '0, rf_e: 1'b0, load: 1'b0};

endpackage : pipeline_pkg
`default_nettype wire

// File: rtl/hazard_forwarding_unit_if.sv
`default_nettype none
// ============================================================================
// Interface : hazard_forwarding_unit_if
// Purpose   : ID-stage operand/control inputs and the forwarding, stall and
//             flush controls returned to the pipeline datapath.
// Revision  : 1.0 - initial release
// ============================================================================
interface hazard_forwarding_unit_if #(
  parameter int RADDR_W = 4,
  parameter int CNT_W   = 8
);

  // ID-stage instruction information
  logic [RADDR_W-1:0] id_ra;
  logic [RADDR_W-1:0] id_rb;
  logic [RADDR_W-1:0] id_rd;
  logic               id_use_ra;
  logic               id_use_rb;
  logic               id_use_rd;
  logic               id_rf_e;
  logic               id_load;
  logic               branch_taken;

  // Control outputs toward the datapath
  logic [1:0]         sel_pa;
  logic [1:0]         sel_pb;
  logic [1:0]         sel_pd;
  logic               pc_le;
  logic               ifid_le;
  logic               nop_ex;
  logic               flush_ifid;
  logic [CNT_W-1:0]   stall_count;

  // Pipeline side: supplies the ID-stage fields, consumes the controls.
  modport master (
    output id_ra, id_rb, id_rd, id_use_ra, id_use_rb, id_use_rd,
           id_rf_e, id_load, branch_taken,
    input  sel_pa, sel_pb, sel_pd, pc_le, ifid_le, nop_ex, flush_ifid,
           stall_count
  );

  // Hazard unit side.
  modport slave (
    input  id_ra, id_rb, id_rd, id_use_ra, id_use_rb, id_use_rd,
           id_rf_e, id_load, branch_taken,
    output sel_pa, sel_pb, sel_pd, pc_le, ifid_le, nop_ex, flush_ifid,
           stall_count
  );

endinterface : hazard_forwarding_unit_if
`default_nettype wire

// File: rtl/hazard_forwarding_unit_fwd_select.sv
`default_nettype none
// ============================================================================
// Module    : fwd_select
// Purpose   : Priority encoder choosing the forwarding source for a single
//             operand: EX over MEM over WB, otherwise the register file.
// Revision  : 1.0 - initial release
// ============================================================================
module fwd_select #(
  parameter int RADDR_W = pipeline_pkg::DEF_RADDR_W,
  parameter int PC_REG  = pipeline_pkg::PC_REG
) (
  input  logic [RADDR_W-1:0] src_i,
  input  logic               use_i,
  input  logic [RADDR_W-1:0] ex_dest_i,
  input  logic               ex_rf_e_i,
  input  logic [RADDR_W-1:0] mem_dest_i,
  input  logic               mem_rf_e_i,
  input  logic [RADDR_W-1:0] wb_dest_i,
  input  logic               wb_rf_e_i,
  output logic [1:0]         sel_o
);

  import pipeline_pkg::*;

  localparam logic [RADDR_W-1:0] PC_ADDR = RADDR_W'(PC_REG);

  logic w_eligible;

  // The PC is never forwarded; otherwise the youngest writer wins.
  always_comb begin
    sel_o      = FWD_RF;
    w_eligible = use_i && (src_i != PC_ADDR);
    if (w_eligible) begin
      if (ex_rf_e_i && (ex_dest_i == src_i)) begin
        sel_o = FWD_EX;
      end else if (mem_rf_e_i && (mem_dest_i == src_i)) begin
        sel_o = FWD_MEM;
      end else if (wb_rf_e_i && (wb_dest_i == src_i)) begin
        sel_o = FWD_WB;
      end
    end
  end

endmodule : fwd_select
`default_nettype wire

// File: rtl/hazard_forwarding_unit.sv
`default_nettype none
// ============================================================================
// Module    : hazard_forwarding_unit
// Purpose   : Hazard detection and operand forwarding for the 5-stage
//             pipeline. Shadows destination info for EX/MEM/WB, drives the
//             PA/PB/PD selects, inserts load-use bubbles and flushes IF/ID
//             on taken branches.
// Revision  : 1.0 - initial release
// ============================================================================
module hazard_forwarding_unit #(
  parameter int RADDR_W = pipeline_pkg::DEF_RADDR_W,
  parameter int PC_REG  = pipeline_pkg::PC_REG,
  parameter int CNT_W   = pipeline_pkg::DEF_CNT_W
) (
  input  logic                     clk,
  input  logic                     reset,
  hazard_forwarding_unit_if.slave  bus
);

  import pipeline_pkg::*;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Shadow pipeline: EX keeps the full record, MEM/WB only need dest/rf_e.
  dest_info_t          ex_q, ex_d;
  logic [RADDR_W-1:0]  mem_dest_q;
  logic                mem_rf_e_q;
  logic [RADDR_W-1:0]  wb_dest_q;
  logic                wb_rf_e_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [1:0]          w_sel_pa;
  logic [1:0]          w_sel_pb;
  logic [1:0]          w_sel_pd;
  logic                w_stall;

  fwd_select #(.RADDR_W(RADDR_W), .PC_REG(PC_REG)) u_fwd_pa (
    .src_i      (bus.id_ra),
    .use_i      (bus.id_use_ra),
    .ex_dest_i  (ex_q.dest),
    .ex_rf_e_i  (ex_q.rf_e),
    .mem_dest_i (mem_dest_q),
    .mem_rf_e_i (mem_rf_e_q),
    .wb_dest_i  (wb_dest_q),
    .wb_rf_e_i  (wb_rf_e_q),
    .sel_o      (w_sel_pa)
  );

  fwd_select #(.RADDR_W(RADDR_W), .PC_REG(PC_REG)) u_fwd_pb (
    .src_i      (bus.id_rb),
    .use_i      (bus.id_use_rb),
    .ex_dest_i  (ex_q.dest),
    .ex_rf_e_i  (ex_q.rf_e),
    .mem_dest_i (mem_dest_q),
    .mem_rf_e_i (mem_rf_e_q),
    .wb_dest_i  (wb_dest_q),
    .wb_rf_e_i  (wb_rf_e_q),
    .sel_o      (w_sel_pb)
  );

  fwd_select #(.RADDR_W(RADDR_W), .PC_REG(PC_REG)) u_fwd_pd (
    .src_i      (bus.id_rd),
    .use_i      (bus.id_use_rd),
    .ex_dest_i  (ex_q.dest),
    .ex_rf_e_i  (ex_q.rf_e),
    .mem_dest_i (mem_dest_q),
    .mem_rf_e_i (mem_rf_e_q),
    .wb_dest_i  (wb_dest_q),
    .wb_rf_e_i  (wb_rf_e_q),
    .sel_o      (w_sel_pd)
  );

  // An operand selecting EX already implies eligibility, rf_e and a dest
  // match, so a load in EX plus any EX select is exactly a load-use hazard.
  always_comb begin
    w_stall = ex_q.load && ((w_sel_pa == FWD_EX) ||
                            (w_sel_pb == FWD_EX) ||
                            (w_sel_pd == FWD_EX));
  end

  // Next EX record: a bubble while stalling, else the ID instruction.
  always_comb begin
    ex_d = DEST_NONE;
    if (!w_stall) begin
      ex_d.dest = bus.id_rd;
      ex_d.rf_e = bus.id_rf_e;
      ex_d.load = bus.id_load;
    end
  end

  // Saturating stall-cycle counter.
  always_comb begin
    cnt_d = cnt_q;
    if (w_stall && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Shadow pipeline advance and counter update; reset clears everything.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_q       <= DEST_NONE;
      mem_dest_q <= '0;
      mem_rf_e_q <= 1'b0;
      wb_dest_q  <= '0;
      wb_rf_e_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      ex_q       <= ex_d;
      mem_dest_q <= ex_q.dest;
      mem_rf_e_q <= ex_q.rf_e;
      wb_dest_q  <= mem_dest_q;
      wb_rf_e_q  <= mem_rf_e_q;
      cnt_q      <= cnt_d;
    end
  end

  // A stalled instruction is held, so a branch seen then is not acted on.
  assign bus.sel_pa      = w_sel_pa;
  assign bus.sel_pb      = w_sel_pb;
  assign bus.sel_pd      = w_sel_pd;
  assign bus.pc_le       = ~w_stall;
  assign bus.ifid_le     = ~w_stall;
  assign bus.nop_ex      = w_stall;
  assign bus.flush_ifid  = bus.branch_taken & ~w_stall;
  assign bus.stall_count = cnt_q;

endmodule : hazard_forwarding_unit
`default_nettype wire

// File: tb/tb_hazard_forwarding_unit.sv
`default_nettype none
// ============================================================================
// Module    : tb_hazard_forwarding_unit
// Purpose   : Directed self-checking bench for hazard_forwarding_unit.
// Revision  : 1.0 - initial release
// ============================================================================
module tb_hazard_forwarding_unit;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;

  // Packed view: {sel_pa, sel_pb, sel_pd, pc_le, ifid_le, nop_ex, flush_ifid}
  localparam logic [9:0] OUT_IDLE = 10'b00_00_00_1_1_0_0;

  hazard_forwarding_unit_if #(.RADDR_W(4), .CNT_W(8)) bus ();

  hazard_forwarding_unit #(.RADDR_W(4), .PC_REG(15), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9:0] outs();
    return {bus.sel_pa, bus.sel_pb, bus.sel_pd,
            bus.pc_le, bus.ifid_le, bus.nop_ex, bus.flush_ifid};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic [3:0] ra, input logic [3:0] rb,
                        input logic [3:0] rd, input logic ura,
                        input logic urb, input logic urd,
                        input logic rfe, input logic ld, input logic br);
    bus.id_ra        = ra;
    bus.id_rb        = rb;
    bus.id_rd        = rd;
    bus.id_use_ra    = ura;
    bus.id_use_rb    = urb;
    bus.id_use_rd    = urd;
    bus.id_rf_e      = rfe;
    bus.id_load      = ld;
    bus.branch_taken = br;
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) begin
      set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
    end
  endtask

  task automatic test_reset();
    logic [9:0] obs;
    set_id(0, 0, 0, 1, 0, 0, 0, 0, 0);
    obs = outs();
    n_checks++;
    if (obs !== OUT_IDLE) $display("FAIL reset_outs: got %b want %b", obs, OUT_IDLE);
    else n_pass++;
    n_checks++;
    if (bus.stall_count !== 8'd0) $display("FAIL reset_count: got %0d want 0", bus.stall_count);
    else n_pass++;
    #1 reset = 1'b1;
    drain();
  endtask

  task automatic test_fwd_ex();
    logic [9:0] obs;
    set_id(0, 0, 1, 0, 0, 0, 1, 0, 0);   // ADD R1
    tick();
    set_id(1, 0, 5, 1, 0, 0, 0, 0, 0);   // reads R1
    obs = outs();
    n_checks++;
    if (obs !== 10'b01_00_00_1_1_0_0) $display("FAIL fwd_ex: got %b want %b", obs, 10'b01_00_00_1_1_0_0);
    else n_pass++;
    tick();
    obs = outs();
    n_checks++;
    if (obs !== 10'b10_00_00_1_1_0_0) $display("FAIL fwd_mem: got %b want %b", obs, 10'b10_00_00_1_1_0_0);
    else n_pass++;
    tick();
    obs = outs();
    n_checks++;
    if (obs !== 10'b11_00_00_1_1_0_0) $display("FAIL fwd_wb: got %b want %b", obs, 10'b11_00_00_1_1_0_0);
    else n_pass++;
    drain();
  endtask

  task automatic test_load_use();
    logic [9:0] obs;
    set_id(0, 0, 3, 0, 0, 0, 1, 1, 0);   // LDR R3
    tick();
    set_id(0, 3, 7, 1, 1, 0, 1, 0, 0);   // ADD R7, R0, R3
    obs = outs();
    n_checks++;
    if (obs !== 10'b00_01_00_0_0_1_0) $display("FAIL lu_stall: got %b want %b", obs, 10'b00_01_00_0_0_1_0);
    else n_pass++;
    n_checks++;
    if (bus.stall_count !== 8'd0) $display("FAIL lu_count0: got %0d want 0", bus.stall_count);
    else n_pass++;
    tick();
    // Load now in MEM; the bubble in EX must not match R0.
    obs = outs();
    n_checks++;
    if (obs !== 10'b00_10_00_1_1_0_0) $display("FAIL lu_after_bubble: got %b want %b", obs, 10'b00_10_00_1_1_0_0);
    else n_pass++;
    n_checks++;
    if (bus.stall_count !== 8'd1) $display("FAIL lu_count1: got %0d want 1", bus.stall_count);
    else n_pass++;
    drain();
  endtask

  task automatic test_priority();
    logic [9:0] obs;
    set_id(0, 0, 2, 0, 0, 0, 1, 0, 0);   // write R2 twice
    tick();
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();                               // EX empty, MEM=R2, WB=R2
    set_id(0, 0, 2, 0, 0, 1, 0, 0, 0);   // store R2
    obs = outs();
    n_checks++;
    if (obs !== 10'b00_00_10_1_1_0_0) $display("FAIL prio_mem_wb: got %b want %b", obs, 10'b00_00_10_1_1_0_0);
    else n_pass++;
    tick();                               // only WB holds R2
    obs = outs();
    n_checks++;
    if (obs !== 10'b00_00_11_1_1_0_0) $display("FAIL prio_wb_only: got %b want %b", obs, 10'b00_00_11_1_1_0_0);
    else n_pass++;
    set_id(0, 0, 15, 0, 0, 0, 1, 1, 0);  // load into R15
    tick();
    set_id(15, 0, 0, 1, 0, 0, 0, 0, 0);
    obs = outs();
    n_checks++;
    if (obs !== OUT_IDLE) $display("FAIL pc_no_fwd: got %b want %b", obs, OUT_IDLE);
    else n_pass++;
    set_id(0, 0, 4, 0, 0, 0, 1, 0, 0);   // write R4 twice
    tick();
    tick();
    set_id(4, 4, 15, 1, 1, 1, 0, 0, 0);
    obs = outs();
    n_checks++;
    if (obs !== 10'b01_01_00_1_1_0_0) $display("FAIL prio_ex_first: got %b want %b", obs, 10'b01_01_00_1_1_0_0);
    else n_pass++;
    set_id(4, 4, 15, 0, 1, 1, 0, 0, 0);
    obs = outs();
    n_checks++;
    if (obs !== 10'b00_01_00_1_1_0_0) $display("FAIL use_gate: got %b want %b", obs, 10'b00_01_00_1_1_0_0);
    else n_pass++;
    drain();
    set_id(0, 0, 0, 0, 0, 0, 1, 0, 0);   // write R0
    tick();
    set_id(0, 0, 0, 1, 0, 0, 0, 0, 0);
    obs = outs();
    n_checks++;
    if (obs !== 10'b01_00_00_1_1_0_0) $display("FAIL r0_fwd: got %b want %b", obs, 10'b01_00_00_1_1_0_0);
    else n_pass++;
    drain();
  endtask

  task automatic test_branch();
    logic [9:0] obs;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 1);
    obs = outs();
    n_checks++;
    if (obs !== 10'b00_00_00_1_1_0_1) $display("FAIL br_flush: got %b want %b", obs, 10'b00_00_00_1_1_0_1);
    else n_pass++;
    set_id(0, 0, 5, 0, 0, 0, 1, 1, 0);   // LDR R5
    tick();
    set_id(0, 5, 0, 0, 1, 0, 0, 0, 1);
    obs = outs();
    n_checks++;
    if (obs !== 10'b00_01_00_0_0_1_0) $display("FAIL br_in_stall: got %b want %b", obs, 10'b00_01_00_0_0_1_0);
    else n_pass++;
    tick();
    obs = outs();
    n_checks++;
    if (obs !== 10'b00_10_00_1_1_0_1) $display("FAIL br_after_stall: got %b want %b", obs, 10'b00_10_00_1_1_0_1);
    else n_pass++;
    drain();
  endtask

  task automatic test_reset_mid_stall();
    logic [9:0] obs;
    set_id(0, 0, 6, 0, 0, 0, 1, 1, 0);   // LDR R6
    tick();
    set_id(6, 0, 0, 1, 0, 0, 0, 0, 0);
    obs = outs();
    n_checks++;
    if (obs !== 10'b01_00_00_0_0_1_0) $display("FAIL rm_stall: got %b want %b", obs, 10'b01_00_00_0_0_1_0);
    else n_pass++;
    n_checks++;
    if (bus.stall_count !== 8'd2) $display("FAIL rm_count_pre: got %0d want 2", bus.stall_count);
    else n_pass++;
    #1 reset = 1'b0;
    #1;
    obs = outs();
    n_checks++;
    if (obs !== OUT_IDLE) $display("FAIL rm_outs: got %b want %b", obs, OUT_IDLE);
    else n_pass++;
    n_checks++;
    if (bus.stall_count !== 8'd0) $display("FAIL rm_count: got %0d want 0", bus.stall_count);
    else n_pass++;
    set_id(0, 0, 6, 0, 0, 0, 1, 1, 0);
    #1 reset = 1'b1;
    tick();                               // first edge captures normally
    set_id(6, 0, 0, 1, 0, 0, 0, 0, 0);
    obs = outs();
    n_checks++;
    if (obs !== 10'b01_00_00_0_0_1_0) $display("FAIL rm_first_edge: got %b want %b", obs, 10'b01_00_00_0_0_1_0);
    else n_pass++;
  endtask

  task automatic test_saturation();
    // Self-dependent load held in ID: stalls on every second edge.
    reset = 1'b0;
    set_id(8, 0, 8, 1, 0, 0, 1, 1, 0);
    #1 reset = 1'b1;
    repeat (20) tick();
    n_checks++;
    if (bus.stall_count !== 8'd10) $display("FAIL sat_20: got %0d want 10", bus.stall_count);
    else n_pass++;
    repeat (488) tick();
    n_checks++;
    if (bus.stall_count !== 8'd254) $display("FAIL sat_508: got %0d want 254", bus.stall_count);
    else n_pass++;
    repeat (2) tick();
    n_checks++;
    if (bus.stall_count !== 8'd255) $display("FAIL sat_510: got %0d want 255", bus.stall_count);
    else n_pass++;
    repeat (90) tick();
    n_checks++;
    if (bus.stall_count !== 8'd255) $display("FAIL sat_600: got %0d want 255", bus.stall_count);
    else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b0;
    test_reset();
    test_fwd_ex();
    test_load_use();
    test_priority();
    test_branch();
    test_reset_mid_stall();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_hazard_forwarding_unit
`default_nettype wire

// File: doc/hazard_forwarding_unit.md
Name: hazard_forwarding_unit

Overview:
- Hazard detection and operand-forwarding controller for the 5-stage ARM-subset pipeline (IF/ID/EX/MEM/WB).
- Keeps its own shadow pipeline of destination-register info for the EX, MEM and WB stages.
- Drives the select lines of the PA/PB/PD operand muxes (RF, EX, MEM or WB value).
- Generates load-use stalls: holds PC and IF/ID, and sets the NOP-select S of the control-signal mux.
- Generates the IF/ID flush on a taken branch.

Parameters:
- RADDR_W, 4, register-address width.
- PC_REG, 15, register index that is never forwarded (read from the RF/PC path).
- CNT_W, 8, width of the saturating stall counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- id_ra  in  RADDR_W  ID-stage source register A (I19..I16).
- id_rb  in  RADDR_W  ID-stage source register B (I3..I0).
- id_rd  in  RADDR_W  ID-stage store-data register and destination (I15..I12).
- id_use_ra  in  1  instruction in ID reads RA.
- id_use_rb  in  1  instruction in ID reads RB.
- id_use_rd  in  1  instruction in ID reads RD (store data for PD).
- id_rf_e  in  1  Control Unit RF_E for the instruction in ID.
- id_load  in  1  Control Unit ID_LOAD for the instruction in ID.
- branch_taken  in  1  Branch or BranchLink from the ConditionHandler.
- sel_pa  out  2  PA mux select: 00 RF, 01 EX, 10 MEM, 11 WB.
- sel_pb  out  2  PB mux select, same encoding as sel_pa.
- sel_pd  out  2  PD mux select, same encoding as sel_pa.
- pc_le  out  1  PC load enable.
- ifid_le  out  1  IF/ID register load enable.
- nop_ex  out  1  S input of the control mux; 1 inserts a bubble into EX.
- flush_ifid  out  1  clears IF/ID to NOP on the next edge.
- stall_count  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Shadow state: ex_{dest,rf_e,load}, mem_{dest,rf_e}, wb_{dest,rf_e}.
- Shadow update on each posedge: WB<=MEM, MEM<=EX.
- EX capture on each posedge:
  - Normally EX<={id_rd, id_rf_e, id_load}.
  - If nop_ex=1, EX captures {0,0,0}.
- Forwarding (combinational from shadow state and ID inputs), per source s in {ra, rb, rd}:
  - A source is eligible only if use_s=1 and s!=PC_REG.
  - An eligible source matches a stage X when X_rf_e=1 and X_dest==s.
  - Priority is EX(01) > MEM(10) > WB(11); no match gives 00.
- Load-use stall:
  - stall = ex_load & ex_rf_e & (ex_dest matches any eligible source).
  - While stall=1: pc_le=0, ifid_le=0, nop_ex=1, and the selects are still driven.
  - Latency: exactly one stall cycle. On the next cycle the load sits in MEM and forwarding selects 10.
- Branch flush:
  - flush_ifid = branch_taken & ~stall.
  - A branch seen while stalled is ignored; the held instruction is re-evaluated next cycle.
- Stall counter: increments on every posedge with stall=1, then saturates at 2^CNT_W-1 and stays there.
- Reset (asynchronous, active-low, effective immediately, including mid-stall):
  - All shadow state cleared.
  - sel_* = 00, pc_le=1, ifid_le=1, nop_ex=0, flush_ifid=0 (given branch_taken=0), stall_count=0.
  - The first edge after reset release behaves as a normal capture.
- Register 0 is an ordinary register and is forwarded like any other.
- Outputs carry no X when inputs are known; all outputs are combinational from registered state plus ID inputs, so no extra latency.

Decomposition:
- Shared package (pipeline_pkg) holds:
  - FWD_RF=2'b00, FWD_EX=2'b01, FWD_MEM=2'b10, FWD_WB=2'b11.
  - PC_REG.
  - A dest_info struct {dest, rf_e, load}.
- One sub-module, fwd_select: a combinational priority encoder taking (src, use, three stage dest/rf_e pairs) and returning a 2-bit select.
  - Instantiated three times, for PA, PB and PD.

Test Plan:
- Forward from EX: ADD R1 with rf_e=1, next cycle ID has ra=1, use_ra=1 -> sel_pa=01, pc_le=1, nop_ex=0.
- Load-use: LDR R3 (load=1, rf_e=1), next ID has rb=3 -> one cycle of pc_le=0/ifid_le=0/nop_ex=1 and stall_count=1, then sel_pb=10 with stall cleared.
- Priority and depth: writes to R2 in WB and MEM -> sel_pd=10; only WB -> 11. ID ra=15 with EX dest 15 -> sel_pa=00.
- Bubble correctness: after the load-use stall, the EX shadow holds rf_e=0, so an ID source of 0 does not forward from EX.
- Branch vs stall: branch_taken=1 with no stall -> flush_ifid=1. branch_taken=1 during a load-use stall -> flush_ifid=0.
- Reset mid-stall: assert reset low during a stall -> immediately pc_le=1, nop_ex=0, sel_*=00, stall_count=0. Counter saturation: force 300 stall cycles -> stall_count=255.
